attack_envelope: RTL and testbench
==================================

// Module: attack_envelope
// PURPOSE
//  Onset (crescendo) counterpart to the dynamics decay stage. At note start it
//  ramps the gain applied to each signed 16-bit sample from 1/8 up to 8/8 in
//  eighth steps, one step per note_duration beats, then holds full scale.
//  Sits between the sample generator and dynamics on the per-note sample path.
// PARAMETERS
//  GAIN_BITS   4   gain register width; max gain 8 means x8/8 (unity)
//  CNT_BITS    6   beat counter width; matches note_duration
// PORTS
//  clk              in   1   system clock, rising edge
//  reset            in   1   asynchronous, active-low reset (0 = reset)
//  note_start       in   1   1-cycle pulse: new note begins
//  done_with_note   in   1   1-cycle pulse: note ended, return to idle
//  note_duration    in   6   beats per gain step; 0 is treated as 1
//  beat             in   1   1-cycle timing pulse from beat generator
//  new_sample_ready in   1   sample_start valid this cycle
//  sample_start     in   16  signed two's-complement raw sample
//  final_sample     out  16  signed scaled sample, registered
//  gain             out  4   current gain numerator, 0..8
//  attack_done      out  1   high while in SUSTAIN (gain == 8)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, gain=0, beat_cnt=0, final_sample=0,
//   attack_done=0. Reset mid-note aborts the note silently.
//  States: IDLE, ATTACK, SUSTAIN.
//   IDLE:    gain=0. note_start -> ATTACK, gain=1, beat_cnt=0.
//   ATTACK:  on beat: if beat_cnt+1 >= max(note_duration,1) then gain+=1,
//            beat_cnt=0, else beat_cnt+=1. Gain reaching 8 -> SUSTAIN.
//   SUSTAIN: gain held at 8; attack_done=1; beats ignored.
//   done_with_note in any state -> IDLE, gain=0, final_sample=0 next edge.
//   note_start in ATTACK/SUSTAIN restarts: gain=1, beat_cnt=0, attack_done=0.
//  Priority, same cycle: note_start > done_with_note > beat.
//  Scaling: final_sample updates only on edges where new_sample_ready=1
//   (latency 1 cycle), otherwise holds. Value = sign(s)*((|s|*g)>>3), i.e.
//   truncation toward zero, computed at 20-bit width; |s| of -32768 taken as
//   32768 at 17 bits; result always fits 16 bits.
//  g used: gain register value before this edge's update, except when
//   note_start is also high (g=1) or done_with_note high (output 0).
//   In IDLE with new_sample_ready, final_sample = 0.
//  A beat on the same cycle as the final step still yields exactly gain=8;
//   gain never exceeds 8; beat_cnt never wraps (cleared at threshold).
//  note_duration is sampled every beat; changing it mid-note affects the
//   current step's threshold immediately (beat_cnt >= new threshold steps).
// TESTING
//  1 note_duration=3, sample 10400, note_start then ready -> final_sample
//    1300; after 3 beats + ready -> 2600; after 21 beats total -> 10400,
//    attack_done=1; further beats leave 10400.
//  2 same with sample -10400 -> -1300, -2600, ... -10400 (sign symmetric);
//    sample -9 at gain 1 -> -1, sample 9 -> 1; sample -32768 at gain 8 ->
//    -32768.
//  3 note_duration=0 -> gain steps every beat; 7 beats after note_start ->
//    gain=8.
//  4 done_with_note at gain 4 -> next edge gain=0, final_sample=0, IDLE;
//    note_start+done_with_note same cycle -> ATTACK, gain=1.
//  5 beat and new_sample_ready same cycle at a step boundary, gain 2->3 ->
//    final_sample uses gain 2; next ready uses 3.
//  6 assert reset low mid-ATTACK between edges -> outputs 0 immediately;
//    release and new note_start ramps again from gain 1.

Source files
------------

// File: rtl/attack_envelope.sv
// attack_envelope
//   Onset (crescendo) stage on the per-note sample path, feeding the dynamics
//   decay stage. At note start the gain applied to each signed 16-bit sample
//   ramps from 1/8 to 8/8 in eighth steps. Each step takes note_duration beats,
//   and a duration of 0 is treated as 1. The gain then holds at full scale
//   until the note ends.
//
// Ports
//   clk              in   1   system clock, rising edge
//   reset            in   1   asynchronous reset, active low (0 = reset)
//   note_start       in   1   one-cycle pulse: a new note begins (restarts ramp)
//   done_with_note   in   1   one-cycle pulse: the note ended, return to idle
//   note_duration    in   6   beats per gain step (0 behaves as 1)
//   beat             in   1   one-cycle timing pulse from the beat generator
//   new_sample_ready in   1   sample_start is valid this cycle
//   sample_start     in   16  signed raw sample
//   final_sample     out  16  signed scaled sample, registered
//   gain             out  4   current gain numerator, 0..8
//   attack_done      out  1   high while the ramp has finished (gain == 8)

module attack_envelope #(
    parameter int GAIN_BITS = 4,
    parameter int CNT_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 note_start,
    input  logic                 done_with_note,
    input  logic [CNT_BITS-1:0]  note_duration,
    input  logic                 beat,
    input  logic                 new_sample_ready,
    input  logic [15:0]          sample_start,
    output logic [15:0]          final_sample,
    output logic [GAIN_BITS-1:0] gain,
    output logic                 attack_done
);

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN
    } state_t;

    localparam logic [GAIN_BITS-1:0] GAIN_MAX = GAIN_BITS'(8);
    localparam logic [GAIN_BITS-1:0] GAIN_ONE = GAIN_BITS'(1);

    state_t               state_q, state_d;
    logic [GAIN_BITS-1:0] gain_q, gain_d;
    logic [CNT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]          final_sample_q, final_sample_d;

    // Scaling datapath signals
    logic [GAIN_BITS-1:0] g_use;
    logic [16:0]          mag;
    logic [19:0]          prod;
    logic [16:0]          scaled;
    logic [16:0]          negd;
    logic [15:0]          scaled_sample;
    logic                 scale_unused;

    // Step threshold and count compare are one bit wider.
    // This keeps beat_cnt+1 from wrapping at the top count.
    logic [CNT_BITS:0]    cnt_inc;
    logic [CNT_BITS:0]    threshold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            gain_q         <= '0;
            beat_cnt_q     <= '0;
            final_sample_q <= '0;
        end else begin
            state_q        <= state_d;
            gain_q         <= gain_d;
            beat_cnt_q     <= beat_cnt_d;
            final_sample_q <= final_sample_d;
        end
    end

    // Sign-magnitude scaling.
    // -32768 has magnitude 32768, which needs 17 bits.
    // Shifting the magnitude right truncates toward zero for both signs.
    // The gain used is the pre-edge register, except on a note_start
    // cycle, where the fresh note already plays at 1/8.
    always_comb begin
        g_use         = note_start ? GAIN_ONE : gain_q;
        mag           = sample_start[15] ? (17'd0 - {1'b1, sample_start})
                                         : {1'b0, sample_start};
        prod          = {3'b000, mag} * {16'h0000, g_use};
        scaled        = prod[19:3];
        negd          = 17'd0 - scaled;
        scaled_sample = sample_start[15] ? negd[15:0] : scaled[15:0];
        scale_unused  = ^{prod[2:0], negd[16]};
    end

    // Next-state logic. The same-cycle priority is note_start, then
    // done_with_note, then beat.
    always_comb begin
        state_d        = state_q;
        gain_d         = gain_q;
        beat_cnt_d     = beat_cnt_q;
        final_sample_d = final_sample_q;
        cnt_inc        = {1'b0, beat_cnt_q} + (CNT_BITS+1)'(1);
        threshold      = (note_duration == '0) ? (CNT_BITS+1)'(1)
                                               : {1'b0, note_duration};

        if (note_start) begin
            state_d    = ATTACK;
            gain_d     = GAIN_ONE;
            beat_cnt_d = '0;
            if (new_sample_ready) begin
                final_sample_d = scaled_sample;
            end
        end else if (done_with_note) begin
            state_d        = IDLE;
            gain_d         = '0;
            beat_cnt_d     = '0;
            final_sample_d = '0;
        end else begin
            if (new_sample_ready) begin
                final_sample_d = scaled_sample;
            end
            case (state_q)
                IDLE: begin
                    gain_d     = '0;
                    beat_cnt_d = '0;
                end
                ATTACK: begin
                    // The threshold is re-read on every beat. Shortening it
                    // mid-step can therefore complete the step at once.
                    if (beat) begin
                        if (cnt_inc >= threshold) begin
                            gain_d     = gain_q + GAIN_ONE;
                            beat_cnt_d = '0;
                            if (gain_q + GAIN_ONE >= GAIN_MAX) begin
                                gain_d  = GAIN_MAX;
                                state_d = SUSTAIN;
                            end
                        end else begin
                            beat_cnt_d = cnt_inc[CNT_BITS-1:0];
                        end
                    end
                end
                SUSTAIN: begin
                    gain_d     = GAIN_MAX;
                    beat_cnt_d = '0;
                end
                default: begin
                    state_d    = IDLE;
                    gain_d     = '0;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end

    assign final_sample = final_sample_q;
    assign gain         = gain_q;
    assign attack_done  = (state_q == SUSTAIN);

endmodule

// File: tb/tb_attack_envelope.sv
// tb_attack_envelope
//   Self-checking bench for attack_envelope. Each applied cycle pushes its
//   expected outputs onto a scoreboard queue. After the clock edge, the entry
//   is popped and compared with the registered outputs. The bench applies a
//   short vector table first, then hand-written multi-cycle sequences for the
//   ramp, duration-0 stepping, note end/restart priority, same-cycle beat and
//   sample, and asynchronous reset.

module tb_attack_envelope;

    typedef struct {
        string       tag;
        logic        ns;
        logic        dn;
        logic        bt;
        logic        rdy;
        logic [5:0]  nd;
        logic [15:0] smp;
        logic [3:0]  eg;
        logic [15:0] es;
        logic        ed;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        note_start;
    logic        done_with_note;
    logic [5:0]  note_duration;
    logic        beat;
    logic        new_sample_ready;
    logic [15:0] sample_start;
    logic [15:0] final_sample;
    logic [3:0]  gain;
    logic        attack_done;

    int   total;
    int   bad;
    vec_t expQ[$];
    vec_t table_v[$];

    attack_envelope dut (
        .clk              (clk),
        .reset            (reset),
        .note_start       (note_start),
        .done_with_note   (done_with_note),
        .note_duration    (note_duration),
        .beat             (beat),
        .new_sample_ready (new_sample_ready),
        .sample_start     (sample_start),
        .final_sample     (final_sample),
        .gain             (gain),
        .attack_done      (attack_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(string tag, bit ns, bit dn, bit bt, bit rdy,
                                   int nd, int smp, int eg, int es, bit ed);
        vec_t v;
        v.tag = tag;
        v.ns  = ns;
        v.dn  = dn;
        v.bt  = bt;
        v.rdy = rdy;
        v.nd  = 6'(nd);
        v.smp = 16'(smp);
        v.eg  = 4'(eg);
        v.es  = 16'(es);
        v.ed  = ed;
        return v;
    endfunction

    // Compare the current outputs against explicit values.
    // Used around the asynchronous reset, where no clock edge is involved.
    task automatic checkNow(input string tag, input int eg, input int es, input bit ed);
        total++;
        if (gain !== 4'(eg)) begin
            bad++;
            $display("[TB] FAIL %s gain got=%0d want=%0d", tag, gain, eg);
        end
        total++;
        if (final_sample !== 16'(es)) begin
            bad++;
            $display("[TB] FAIL %s final_sample got=%0d want=%0d", tag,
                     $signed(final_sample), es);
        end
        total++;
        if (attack_done !== ed) begin
            bad++;
            $display("[TB] FAIL %s attack_done got=%0b want=%0b", tag, attack_done, ed);
        end
    endtask

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard empty got=%0d want=1", expQ.size());
            return;
        end
        e = expQ.pop_front();
        total++;
        if (gain !== e.eg) begin
            bad++;
            $display("[TB] FAIL %s gain got=%0d want=%0d", e.tag, gain, e.eg);
        end
        total++;
        if (final_sample !== e.es) begin
            bad++;
            $display("[TB] FAIL %s final_sample got=%0d want=%0d", e.tag,
                     $signed(final_sample), $signed(e.es));
        end
        total++;
        if (attack_done !== e.ed) begin
            bad++;
            $display("[TB] FAIL %s attack_done got=%0b want=%0b", e.tag,
                     attack_done, e.ed);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and record its
    // expectation. Check the outputs shortly after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        note_start       = v.ns;
        done_with_note   = v.dn;
        beat             = v.bt;
        new_sample_ready = v.rdy;
        note_duration    = v.nd;
        sample_start     = v.smp;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleInputs();
        note_start       = 1'b0;
        done_with_note   = 1'b0;
        beat             = 1'b0;
        new_sample_ready = 1'b0;
        sample_start     = 16'h0000;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        note_duration = 6'd3;
        idleInputs();

        #3;
        checkNow("resetState", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Fields: tag, ns, dn, beat, ready, nd, sample, exp gain, exp sample, exp done.
        table_v.push_back(mkVec("idleReady",   0, 0, 0, 1, 3,  10400, 0,     0, 0));
        table_v.push_back(mkVec("noteStart",   1, 0, 0, 0, 3,      0, 1,     0, 0));
        table_v.push_back(mkVec("gain1Pos",    0, 0, 0, 1, 3,  10400, 1,  1300, 0));
        table_v.push_back(mkVec("beat1",       0, 0, 1, 0, 3,      0, 1,  1300, 0));
        table_v.push_back(mkVec("beat2",       0, 0, 1, 0, 3,      0, 1,  1300, 0));
        table_v.push_back(mkVec("beat3Step",   0, 0, 1, 0, 3,      0, 2,  1300, 0));
        table_v.push_back(mkVec("gain2Pos",    0, 0, 0, 1, 3,  10400, 2,  2600, 0));
        table_v.push_back(mkVec("gain2Neg",    0, 0, 0, 1, 3, -10400, 2, -2600, 0));
        table_v.push_back(mkVec("restartNeg9", 1, 0, 0, 1, 3,     -9, 1,    -1, 0));
        table_v.push_back(mkVec("pos9",        0, 0, 0, 1, 3,      9, 1,     1, 0));
        table_v.push_back(mkVec("pos7Trunc",   0, 0, 0, 1, 3,      7, 1,     0, 0));
        table_v.push_back(mkVec("neg7Trunc",   0, 0, 0, 1, 3,     -7, 1,     0, 0));
        table_v.push_back(mkVec("doneIdle",    0, 1, 0, 0, 3,      0, 0,     0, 0));
        for (int i = 0; i < table_v.size(); i++) begin
            applyStimulus(table_v[i]);
        end

        // Full ramp at three beats per step with a 10400 sample.
        applyStimulus(mkVec("rampStart", 1, 0, 0, 0, 3,     0, 1,    0, 0));
        applyStimulus(mkVec("rampG1",    0, 0, 0, 1, 3, 10400, 1, 1300, 0));
        for (int step = 1; step <= 7; step++) begin
            for (int b = 0; b < 3; b++) begin
                applyStimulus(mkVec("rampBeat", 0, 0, 1, 0, 3, 0,
                                    (b == 2) ? step + 1 : step, 1300 * step,
                                    (b == 2) && (step == 7)));
            end
            applyStimulus(mkVec("rampReady", 0, 0, 0, 1, 3, 10400, step + 1,
                                1300 * (step + 1), step == 7));
        end
        for (int b = 0; b < 3; b++) begin
            applyStimulus(mkVec("sustainBeat", 0, 0, 1, 0, 3, 0, 8, 10400, 1));
        end
        applyStimulus(mkVec("fullNegMax", 0, 0, 0, 1, 3, -32768, 8, -32768, 1));
        applyStimulus(mkVec("fullPosMax", 0, 0, 0, 1, 3,  32767, 8,  32767, 1));
        applyStimulus(mkVec("fullNeg1",   0, 0, 0, 1, 3,     -1, 8,     -1, 1));
        applyStimulus(mkVec("fullPos5",   0, 0, 0, 1, 3,      5, 8,      5, 1));

        // A duration of 0 steps on every beat.
        applyStimulus(mkVec("nd0Start", 1, 0, 0, 0, 0, 0, 1, 5, 0));
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(mkVec("nd0Beat", 0, 0, 1, 0, 0, 0, k + 1, 5, k == 7));
        end
        applyStimulus(mkVec("nd0Hold", 0, 0, 1, 0, 0, 0, 8, 5, 1));

        // End the note at gain 4, then test note_start beating done_with_note.
        applyStimulus(mkVec("g4Start", 1, 0, 0, 0, 1, 0, 1, 5, 0));
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(mkVec("g4Beat", 0, 0, 1, 0, 1, 0, k, 5, 0));
        end
        applyStimulus(mkVec("g4Ready",     0, 0, 0, 1, 1, 10400, 4, 5200, 0));
        applyStimulus(mkVec("doneAtG4",    0, 1, 0, 0, 1,     0, 0,    0, 0));
        applyStimulus(mkVec("idleAgain",   0, 0, 0, 1, 1, 10400, 0,    0, 0));
        applyStimulus(mkVec("startAndDone",1, 1, 0, 1, 2, 10400, 1, 1300, 0));

        // A beat and a sample arrive together at a step boundary.
        // The sample must use the pre-step gain.
        applyStimulus(mkVec("bndBeatA",   0, 0, 1, 0, 2,     0, 1, 1300, 0));
        applyStimulus(mkVec("bndBeatB",   0, 0, 1, 0, 2,     0, 2, 1300, 0));
        applyStimulus(mkVec("bndBeatC",   0, 0, 1, 0, 2,     0, 2, 1300, 0));
        applyStimulus(mkVec("bndBoth",    0, 0, 1, 1, 2, 10400, 3, 2600, 0));
        applyStimulus(mkVec("bndNext",    0, 0, 0, 1, 2, 10400, 3, 3900, 0));
        // Shortening note_duration mid-step completes the step on the next beat.
        applyStimulus(mkVec("ndLongA",    0, 0, 1, 0, 5,     0, 3, 3900, 0));
        applyStimulus(mkVec("ndLongB",    0, 0, 1, 0, 5,     0, 3, 3900, 0));
        applyStimulus(mkVec("ndShort",    0, 0, 1, 0, 2,     0, 4, 3900, 0));
        applyStimulus(mkVec("ndShortRdy", 0, 0, 0, 1, 2, 10400, 4, 5200, 0));
        applyStimulus(mkVec("cntClrA",    0, 0, 1, 0, 2,     0, 4, 5200, 0));
        applyStimulus(mkVec("cntClrB",    0, 0, 1, 0, 2,     0, 5, 5200, 0));

        // Asynchronous reset between edges in the middle of the ramp.
        @(negedge clk);
        idleInputs();
        #2;
        reset = 1'b0;
        #1;
        checkNow("asyncReset", 0, 0, 0);
        @(posedge clk);
        #1;
        checkNow("resetHeld", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(mkVec("postRstStart", 1, 0, 1, 1, 3, 10400, 1, 1300, 0));
        applyStimulus(mkVec("postRstBeatA", 0, 0, 1, 0, 3,     0, 1, 1300, 0));
        applyStimulus(mkVec("postRstBeatB", 0, 0, 1, 0, 3,     0, 1, 1300, 0));
        applyStimulus(mkVec("postRstBeatC", 0, 0, 1, 0, 3,     0, 2, 1300, 0));

        @(negedge clk);
        idleInputs();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard leftover got=%0d want=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
